rr_arbiter_8: RTL

Round-robin arbiter that shares one downstream resource between eight requesters. Built around a combinational LSB-first priority encoder applied to a rotated request vector. Produces a registered one-hot grant plus its 3-bit index. Grants are held while the owner keeps requesting, and are preempted after a configurable hold limit when other requesters are waiting.

---
 rtl/rr_arb_pkg.sv | 18 +
 rtl/rr_prio_enc.sv | 30 +++
 rtl/rr_arbiter_8.sv | 133 +++++++++++++
 3 files changed

// File: rtl/rr_arb_pkg.sv
// Shared constants, state type and helpers for the 8-way round-robin arbiter.
package rr_arb_pkg;

    localparam int NREQ = 8;
    localparam int IDW  = 3;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    function automatic logic [NREQ-1:0] id2onehot(input logic [IDW-1:0] id);
        logic [NREQ-1:0] oh;
        oh = {{(NREQ-1){1'b0}}, 1'b1} << id;
        return oh;
    endfunction

endpackage

// File: rtl/rr_prio_enc.sv
// 8-to-3 LSB-first priority encoder: lowest set bit wins, out=0 when nothing is set.
module rr_prio_enc
    import rr_arb_pkg::*;
(
    input  logic [NREQ-1:0] in,
    output logic [IDW-1:0]  out,
    output logic            valid
);

    // Lowest-index match decode
    always_comb begin
        out   = 3'd0;
        valid = 1'b1;
        casez (in)
            8'b???????1: out = 3'd0;
            8'b??????10: out = 3'd1;
            8'b?????100: out = 3'd2;
            8'b????1000: out = 3'd3;
            8'b???10000: out = 3'd4;
            8'b??100000: out = 3'd5;
            8'b?1000000: out = 3'd6;
            8'b10000000: out = 3'd7;
            default: begin
                out   = 3'd0;
                valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with registered one-hot grant and a hold limit
// that forces the owner to yield when others are waiting.
module rr_arbiter_8
    import rr_arb_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id,
    output logic            gnt_valid
);

    localparam logic [7:0] HOLD_LIM   = (MAX_HOLD == 0) ? 8'd255 : 8'(MAX_HOLD - 1);
    localparam logic       PREEMPT_EN = (MAX_HOLD != 0);

    arb_state_t      state_r, state_nxt_s;
    logic [IDW-1:0]  ptr_r, ptr_nxt_s;
    logic [7:0]      hold_cnt_r, hold_nxt_s;
    logic [NREQ-1:0] gnt_r, gnt_nxt_s;
    logic [IDW-1:0]  gnt_id_r, id_nxt_s;
    logic            gnt_valid_r, valid_nxt_s;

    logic [NREQ-1:0] req_m_s;
    logic [NREQ-1:0] rot_s;
    logic [IDW-1:0]  enc_k_s;
    logic            enc_v_s;
    logic [IDW-1:0]  winner_s;
    logic            owner_req_s;
    logic            take_s;
    logic            idle_s;

    // Owner is always excluded from the search, so the winner is only ever another requester
    always_comb begin
        req_m_s     = req & ~gnt_r;
        owner_req_s = |(req & gnt_r);
        rot_s       = '0;
        for (int k = 0; k < NREQ; k++) begin
            rot_s[k] = req_m_s[ptr_r + 3'(k)];
        end
    end

    rr_prio_enc u_enc (
        .in    (rot_s),
        .out   (enc_k_s),
        .valid (enc_v_s)
    );

    assign winner_s = ptr_r + enc_k_s;

    // Release / preempt / hold decision and next-state values
    always_comb begin
        take_s      = 1'b0;
        idle_s      = 1'b0;
        state_nxt_s = state_r;
        ptr_nxt_s   = ptr_r;
        hold_nxt_s  = hold_cnt_r;
        gnt_nxt_s   = gnt_r;
        id_nxt_s    = gnt_id_r;
        valid_nxt_s = gnt_valid_r;

        case (state_r)
            ARB_IDLE: begin
                if (enc_v_s) begin
                    take_s = 1'b1;
                end else begin
                    idle_s = 1'b1;
                end
            end
            ARB_GRANT: begin
                if (!owner_req_s) begin
                    if (enc_v_s) begin
                        take_s = 1'b1;
                    end else begin
                        idle_s = 1'b1;
                    end
                end else if (PREEMPT_EN && (hold_cnt_r == HOLD_LIM) && enc_v_s) begin
                    take_s = 1'b1;
                end else if (hold_cnt_r != HOLD_LIM) begin
                    hold_nxt_s = hold_cnt_r + 8'd1;
                end else begin
                    hold_nxt_s = hold_cnt_r;
                end
            end
            default: begin
                idle_s = 1'b1;
            end
        endcase

        if (take_s) begin
            state_nxt_s = ARB_GRANT;
            gnt_nxt_s   = id2onehot(winner_s);
            id_nxt_s    = winner_s;
            valid_nxt_s = 1'b1;
            hold_nxt_s  = 8'd0;
            ptr_nxt_s   = winner_s + 3'd1;
        end else if (idle_s) begin
            state_nxt_s = ARB_IDLE;
            gnt_nxt_s   = 8'd0;
            id_nxt_s    = 3'd0;
            valid_nxt_s = 1'b0;
            hold_nxt_s  = 8'd0;
        end else begin
            state_nxt_s = ARB_GRANT;
        end
    end

    // State, pointer, hold counter and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ARB_IDLE;
            ptr_r       <= 3'd0;
            hold_cnt_r  <= 8'd0;
            gnt_r       <= 8'd0;
            gnt_id_r    <= 3'd0;
            gnt_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            ptr_r       <= ptr_nxt_s;
            hold_cnt_r  <= hold_nxt_s;
            gnt_r       <= gnt_nxt_s;
            gnt_id_r    <= id_nxt_s;
            gnt_valid_r <= valid_nxt_s;
        end
    end

    assign gnt       = gnt_r;
    assign gnt_id    = gnt_id_r;
    assign gnt_valid = gnt_valid_r;

endmodule
